quad_encoder_multi: RTL and testbench

- Fully synchronous, N-channel x4 quadrature decoder for the motor encoders.
- Per channel it produces:
  - a signed wrap-around position counter;
  - a signed tick count per measurement window (speed);
  - a direction flag;
  - an invalid-transition error counter.
- Sits between the encoder pins and the register/SPI interface.
- All logic runs on clk. No encoder signal is used as a clock.

---
 rtl/enc_pkg.sv | 35 +++
 rtl/quad_channel.sv | 126 ++++++++++++
 rtl/quad_encoder_multi.sv | 94 +++++++++
 tb/tb_quad_encoder_multi.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared types and helpers for the multi-channel x4 quadrature decoder.
// Steps follow the Gray sequence 00->01->11->10->00 as the forward direction.
package enc_pkg;

    localparam int DEFAULT_WINDOW_CYCLES = 5000000;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_FWD,
        STEP_REV,
        STEP_ERR
    } step_t;

    // Position of an {A,B} pair along the forward Gray cycle.
    function automatic logic [1:0] gray_index(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic step_t decode_step(input logic [1:0] prev, input logic [1:0] cur);
        logic [1:0] diff;
        diff = gray_index(cur) - gray_index(prev);
        case (diff)
            2'd0:    return STEP_NONE;
            2'd1:    return STEP_FWD;
            2'd3:    return STEP_REV;
            default: return STEP_ERR;
        endcase
    endfunction

endpackage

// File: rtl/quad_channel.sv
// One encoder channel: 2-FF synchronizers, optional glitch filter (ENC_GLITCH_FILTER_EN),
// step decode, wrap-around position, direction and saturating error count.
module quad_channel
    import enc_pkg::*;
#(
    parameter int POS_W = 32,
    parameter int ERR_W = 8
`ifdef ENC_GLITCH_FILTER_EN
    ,
    parameter int FILT_LEN = 4
`endif
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_en,
    input  logic                    i_inA,
    input  logic                    i_inB,
    input  logic                    i_clrPos,
    output logic [POS_W-1:0]        o_position,
    output logic                    o_direction,
    output logic [ERR_W-1:0]        o_errCount,
    output logic signed [1:0]       o_delta
);

    logic [1:0]        r_syncA;
    logic [1:0]        r_syncB;
    logic [1:0]        w_cur;
    logic [1:0]        r_prev;
    logic              r_primed;
    logic [POS_W-1:0]  r_position;
    logic              r_direction;
    logic [ERR_W-1:0]  r_errCount;
    step_t             w_step;
    logic              w_active;
    logic signed [1:0] w_delta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_syncA <= '0;
            r_syncB <= '0;
        end else begin
            r_syncA <= {r_syncA[0], i_inA};
            r_syncB <= {r_syncB[0], i_inB};
        end
    end

`ifdef ENC_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILT_LEN + 1);

    logic [1:0]          w_raw;
    logic [1:0]          r_filt;
    logic [1:0][CW-1:0]  r_cnt;

    assign w_raw = {r_syncA[1], r_syncB[1]};

    // A new level is accepted on its FILT_LEN-th consecutive cycle; any return resets the run.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_filt <= '0;
            r_cnt  <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_raw[i] == r_filt[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CW'(FILT_LEN - 1)) begin
                    r_filt[i] <= w_raw[i];
                    r_cnt[i]  <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_cur = r_filt;
`else
    assign w_cur = {r_syncA[1], r_syncB[1]};
`endif

    assign w_step   = decode_step(r_prev, w_cur);
    assign w_active = i_en && r_primed;

    always_comb begin
        w_delta = 2'sb00;
        if (w_active && w_step == STEP_FWD) begin
            w_delta = 2'sb01;
        end else if (w_active && w_step == STEP_REV) begin
            w_delta = 2'sb11;
        end
    end

    // prev follows cur unconditionally so re-enabling never produces a phantom step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev      <= '0;
            r_primed    <= 1'b0;
            r_position  <= '0;
            r_direction <= 1'b0;
            r_errCount  <= '0;
        end else begin
            r_prev   <= w_cur;
            r_primed <= 1'b1;
            if (i_clrPos) begin
                r_position <= '0;
            end else if (w_delta == 2'sb01) begin
                r_position <= r_position + 1'b1;
            end else if (w_delta == 2'sb11) begin
                r_position <= r_position - 1'b1;
            end
            if (w_active) begin
                case (w_step)
                    STEP_FWD: r_direction <= 1'b1;
                    STEP_REV: r_direction <= 1'b0;
                    STEP_ERR: if (r_errCount != '1) r_errCount <= r_errCount + 1'b1;
                    default:  ;
                endcase
            end
        end
    end

    assign o_position  = r_position;
    assign o_direction = r_direction;
    assign o_errCount  = r_errCount;
    assign o_delta     = w_delta;

endmodule

// File: rtl/quad_encoder_multi.sv
// N-channel x4 quadrature decoder: per-channel decoders plus a shared speed window.
// Optional input glitch filter is enabled by defining ENC_GLITCH_FILTER_EN.
module quad_encoder_multi
    import enc_pkg::*;
#(
    parameter int NCH           = 2,
    parameter int WINDOW_CYCLES = DEFAULT_WINDOW_CYCLES,
    parameter int SPEED_W       = 16,
    parameter int POS_W         = 32,
    parameter int ERR_W         = 8,
    parameter int FILT_LEN      = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          en,
    input  logic [NCH-1:0]                inA,
    input  logic [NCH-1:0]                inB,
    input  logic [NCH-1:0]                clr_pos,
    output logic [NCH-1:0][POS_W-1:0]     position,
    output logic [NCH-1:0][SPEED_W-1:0]   speed,
    output logic [NCH-1:0]                direction,
    output logic                          speed_valid,
    output logic [NCH-1:0][ERR_W-1:0]     err_count
);

    localparam int WCW = $clog2(WINDOW_CYCLES);
    localparam logic [SPEED_W-1:0] SPEED_MAX = {1'b0, {(SPEED_W-1){1'b1}}};
    localparam logic [SPEED_W-1:0] SPEED_MIN = {1'b1, {(SPEED_W-1){1'b0}}};

    logic [WCW-1:0]              r_winCnt;
    logic                        w_terminal;
    logic [NCH-1:0][1:0]         w_delta;
    logic [NCH-1:0][SPEED_W-1:0] w_accNext;
    logic [NCH-1:0][SPEED_W-1:0] r_acc;
    logic [NCH-1:0][SPEED_W-1:0] r_speed;
    logic                        r_speedValid;

    // Accumulate a -1/0/+1 delta, clamping at the signed limits instead of wrapping.
    function automatic logic [SPEED_W-1:0] satAdd(input logic [SPEED_W-1:0] a, input logic [1:0] d);
        if (d == 2'b01 && a == SPEED_MAX) return a;
        if (d == 2'b11 && a == SPEED_MIN) return a;
        return a + {{(SPEED_W-2){d[1]}}, d};
    endfunction

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        quad_channel #(
            .POS_W    (POS_W),
            .ERR_W    (ERR_W)
`ifdef ENC_GLITCH_FILTER_EN
            ,
            .FILT_LEN (FILT_LEN)
`endif
        ) u_ch (
            .clk         (clk),
            .reset_n     (reset_n),
            .i_en        (en),
            .i_inA       (inA[c]),
            .i_inB       (inB[c]),
            .i_clrPos    (clr_pos[c]),
            .o_position  (position[c]),
            .o_direction (direction[c]),
            .o_errCount  (err_count[c]),
            .o_delta     (w_delta[c])
        );

        assign w_accNext[c] = satAdd(r_acc[c], w_delta[c]);
    end

    assign w_terminal = en && (r_winCnt == WCW'(WINDOW_CYCLES - 1));

    // The terminal cycle's own delta is folded into the published speed so no tick is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_winCnt     <= '0;
            r_acc        <= '0;
            r_speed      <= '0;
            r_speedValid <= 1'b0;
        end else begin
            r_speedValid <= w_terminal;
            if (w_terminal) begin
                r_winCnt <= '0;
                r_acc    <= '0;
                r_speed  <= w_accNext;
            end else if (en) begin
                r_winCnt <= r_winCnt + 1'b1;
                r_acc    <= w_accNext;
            end
        end
    end

    assign speed       = r_speed;
    assign speed_valid = r_speedValid;

endmodule

// File: tb/tb_quad_encoder_multi.sv
// Directed self-checking bench for quad_encoder_multi (NCH=2, 100-cycle window, 8-bit speed).
// Define ENC_GLITCH_FILTER_EN to run the filter-specific subset.
module tb_quad_encoder_multi;

    localparam int NCH = 2;
    localparam int WIN = 100;
    localparam int SW  = 8;
    localparam int PW  = 32;
    localparam int EW  = 8;
    localparam int FL  = 4;
`ifdef ENC_GLITCH_FILTER_EN
    localparam int LAT = 3 + FL;
`else
    localparam int LAT = 3;
`endif

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic                     en;
    logic [NCH-1:0]           inA;
    logic [NCH-1:0]           inB;
    logic [NCH-1:0]           clr_pos;
    logic [NCH-1:0][PW-1:0]   position;
    logic [NCH-1:0][SW-1:0]   speed;
    logic [NCH-1:0]           direction;
    logic                     speed_valid;
    logic [NCH-1:0][EW-1:0]   err_count;

    logic [NCH-1:0][PW-1:0]   satPosition;
    logic [NCH-1:0][SW-1:0]   satSpeed;
    logic [NCH-1:0]           satDirection;
    logic                     satSpeedValid;
    logic [NCH-1:0][EW-1:0]   satErrCount;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int phase [NCH];
    logic [1:0] fwdSeq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    quad_encoder_multi #(
        .NCH(NCH), .WINDOW_CYCLES(WIN), .SPEED_W(SW), .POS_W(PW), .ERR_W(EW), .FILT_LEN(FL)
    ) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .inA(inA), .inB(inB), .clr_pos(clr_pos),
        .position(position), .speed(speed), .direction(direction),
        .speed_valid(speed_valid), .err_count(err_count)
    );

    // Longer window so more than 127 steps fit and the speed accumulator saturates.
    quad_encoder_multi #(
        .NCH(NCH), .WINDOW_CYCLES(400), .SPEED_W(SW), .POS_W(PW), .ERR_W(EW), .FILT_LEN(FL)
    ) dutSat (
        .clk(clk), .reset_n(reset_n), .en(en), .inA(inA), .inB(inB), .clr_pos(clr_pos),
        .position(satPosition), .speed(satSpeed), .direction(satDirection),
        .speed_valid(satSpeedValid), .err_count(satErrCount)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic setPins(input int ch);
        {inA[ch], inB[ch]} = fwdSeq[phase[ch]];
    endtask

    task automatic doReset(input int startPhase);
        reset_n = 1'b0;
        en      = 1'b1;
        clr_pos = '0;
        for (int c = 0; c < NCH; c++) begin
            phase[c] = startPhase;
            setPins(c);
        end
        tick(3);
        reset_n = 1'b1;
        cyc = 0;
    endtask

    task automatic step(input int ch, input int dir, input int n, input int hold);
        repeat (n) begin
            phase[ch] = (phase[ch] + dir + 4) % 4;
            setPins(ch);
            tick(hold);
        end
    endtask

    task automatic waitValid(input bit useSat, input int maxCyc, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < maxCyc; i++) begin
            tick(1);
            if ((useSat ? satSpeedValid : speed_valid) === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s: speed_valid not seen within %0d cycles", name, maxCyc);
        end
    endtask

    task automatic test_reset();
        doReset(0);
        checks++;
        if (position !== '0) begin failures++; $display("FAIL reset_position: got %h expected 0", position); end
        checks++;
        if (speed !== '0) begin failures++; $display("FAIL reset_speed: got %h expected 0", speed); end
        checks++;
        if (err_count !== '0) begin failures++; $display("FAIL reset_err: got %h expected 0", err_count); end
        checks++;
        if (direction !== '0) begin failures++; $display("FAIL reset_direction: got %b expected 0", direction); end
        checks++;
        if (speed_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", speed_valid); end
    endtask

    task automatic test_latency();
        int p;
        doReset(0);
        tick(4);
        step(0, 1, 1, LAT - 1);
        p = $signed(position[0]);
        checks++;
        if (p !== 0) begin failures++; $display("FAIL latency_early: got %0d expected 0", p); end
        tick(1);
        p = $signed(position[0]);
        checks++;
        if (p !== 1) begin failures++; $display("FAIL latency_on_time: got %0d expected 1", p); end
    endtask

    task automatic test_forward();
        int s0, s1, p0;
        doReset(0);
        tick(4);
        step(0, 1, 40, 2);
        waitValid(1'b0, 50, "forward_valid");
        s0 = $signed(speed[0]);
        s1 = $signed(speed[1]);
        p0 = $signed(position[0]);
        checks++;
        if (cyc !== WIN) begin failures++; $display("FAIL forward_valid_cycle: got %0d expected %0d", cyc, WIN); end
        checks++;
        if (s0 !== 40) begin failures++; $display("FAIL forward_speed0: got %0d expected 40", s0); end
        checks++;
        if (s1 !== 0) begin failures++; $display("FAIL forward_speed1: got %0d expected 0", s1); end
        checks++;
        if (p0 !== 40) begin failures++; $display("FAIL forward_position0: got %0d expected 40", p0); end
        checks++;
        if (direction[0] !== 1'b1) begin failures++; $display("FAIL forward_direction0: got %b expected 1", direction[0]); end
    endtask

    task automatic test_reverse();
        int s0, s1, p1;
        doReset(0);
        tick(4);
        step(1, 1, 2, 2);
        step(1, -1, 32, 2);
        waitValid(1'b0, 50, "reverse_valid");
        s0 = $signed(speed[0]);
        s1 = $signed(speed[1]);
        p1 = $signed(position[1]);
        checks++;
        if (s1 !== -30) begin failures++; $display("FAIL reverse_speed1: got %0d expected -30", s1); end
        checks++;
        if (p1 !== -30) begin failures++; $display("FAIL reverse_position1: got %0d expected -30", p1); end
        checks++;
        if (direction[1] !== 1'b0) begin failures++; $display("FAIL reverse_direction1: got %b expected 0", direction[1]); end
        checks++;
        if (s0 !== 0) begin failures++; $display("FAIL reverse_speed0: got %0d expected 0", s0); end
    endtask

    task automatic test_errors();
        int p0;
        doReset(0);
        tick(4);
        repeat (5) begin
            {inA[0], inB[0]} = ~{inA[0], inB[0]};
            tick(2);
        end
        tick(4);
        p0 = $signed(position[0]);
        checks++;
        if (err_count[0] !== 8'd5) begin failures++; $display("FAIL err_five: got %0d expected 5", err_count[0]); end
        checks++;
        if (p0 !== 0) begin failures++; $display("FAIL err_position: got %0d expected 0", p0); end
        repeat (300) begin
            {inA[0], inB[0]} = ~{inA[0], inB[0]};
            tick(2);
        end
        tick(4);
        p0 = $signed(position[0]);
        checks++;
        if (err_count[0] !== 8'd255) begin failures++; $display("FAIL err_saturate: got %0d expected 255", err_count[0]); end
        checks++;
        if (p0 !== 0) begin failures++; $display("FAIL err_position_after: got %0d expected 0", p0); end
        checks++;
        if (err_count[1] !== 8'd0) begin failures++; $display("FAIL err_other_channel: got %0d expected 0", err_count[1]); end
    endtask

    task automatic test_terminal();
        int s0, p0;
        doReset(0);
        tick(WIN - LAT);
        step(0, 1, 1, 0);
        waitValid(1'b0, 10, "terminal_valid");
        s0 = $signed(speed[0]);
        p0 = $signed(position[0]);
        checks++;
        if (cyc !== WIN) begin failures++; $display("FAIL terminal_cycle: got %0d expected %0d", cyc, WIN); end
        checks++;
        if (s0 !== 1) begin failures++; $display("FAIL terminal_speed: got %0d expected 1", s0); end
        checks++;
        if (p0 !== 1) begin failures++; $display("FAIL terminal_position: got %0d expected 1", p0); end
        waitValid(1'b0, WIN + 10, "terminal_next_valid");
        s0 = $signed(speed[0]);
        checks++;
        if (s0 !== 0) begin failures++; $display("FAIL terminal_next_speed: got %0d expected 0", s0); end
    endtask

    task automatic test_saturation();
        int s0, s1, p0, p1;
        doReset(0);
        tick(4);
        repeat (200) begin
            phase[0] = (phase[0] + 1) % 4;
            phase[1] = (phase[1] + 3) % 4;
            setPins(0);
            setPins(1);
            tick(1);
        end
        waitValid(1'b1, 300, "sat_valid");
        s0 = $signed(satSpeed[0]);
        s1 = $signed(satSpeed[1]);
        p0 = $signed(satPosition[0]);
        p1 = $signed(satPosition[1]);
        checks++;
        if (s0 !== 127) begin failures++; $display("FAIL sat_speed_pos: got %0d expected 127", s0); end
        checks++;
        if (s1 !== -128) begin failures++; $display("FAIL sat_speed_neg: got %0d expected -128", s1); end
        checks++;
        if (p0 !== 200) begin failures++; $display("FAIL sat_position0: got %0d expected 200", p0); end
        checks++;
        if (p1 !== -200) begin failures++; $display("FAIL sat_position1: got %0d expected -200", p1); end
    endtask

    task automatic test_clear();
        int p0, s0;
        doReset(2);
        tick(6);
        p0 = $signed(position[0]);
        checks++;
        if (p0 !== 0) begin failures++; $display("FAIL clear_reset_at_11: got %0d expected 0", p0); end
        step(0, 1, 3, 2);
        p0 = $signed(position[0]);
        checks++;
        if (p0 !== 2) begin failures++; $display("FAIL clear_pre_steps: got %0d expected 2", p0); end
        tick(2);
        phase[0] = (phase[0] + 1) % 4;
        setPins(0);
        tick(2);
        clr_pos = 2'b01;
        tick(1);
        clr_pos = 2'b00;
        p0 = $signed(position[0]);
        checks++;
        if (p0 !== 0) begin failures++; $display("FAIL clear_position: got %0d expected 0", p0); end
        waitValid(1'b0, WIN, "clear_valid");
        s0 = $signed(speed[0]);
        checks++;
        if (s0 !== 4) begin failures++; $display("FAIL clear_speed: got %0d expected 4", s0); end
    endtask

    task automatic test_enable();
        int p0, s0;
        doReset(0);
        en = 1'b0;
        tick(4);
        step(0, 1, 3, 2);
        tick(3);
        p0 = $signed(position[0]);
        checks++;
        if (p0 !== 0) begin failures++; $display("FAIL enable_off_position: got %0d expected 0", p0); end
        en = 1'b1;
        tick(5);
        p0 = $signed(position[0]);
        checks++;
        if (p0 !== 0) begin failures++; $display("FAIL enable_no_phantom: got %0d expected 0", p0); end
        waitValid(1'b0, WIN + 10, "enable_valid");
        s0 = $signed(speed[0]);
        checks++;
        if (cyc !== WIN + 13) begin failures++; $display("FAIL enable_window_hold: got %0d expected %0d", cyc, WIN + 13); end
        checks++;
        if (s0 !== 0) begin failures++; $display("FAIL enable_speed: got %0d expected 0", s0); end
    endtask

`ifdef ENC_GLITCH_FILTER_EN
    task automatic test_glitch();
        int p0;
        doReset(0);
        tick(4);
        inA[0] = 1'b1;
        tick(3);
        inA[0] = 1'b0;
        tick(12);
        p0 = $signed(position[0]);
        checks++;
        if (p0 !== 0) begin failures++; $display("FAIL glitch_position: got %0d expected 0", p0); end
        checks++;
        if (err_count[0] !== 8'd0) begin failures++; $display("FAIL glitch_err: got %0d expected 0", err_count[0]); end
        inA[0] = 1'b1;
        tick(6);
        p0 = $signed(position[0]);
        checks++;
        if (p0 !== 0) begin failures++; $display("FAIL glitch_early: got %0d expected 0", p0); end
        tick(1);
        p0 = $signed(position[0]);
        checks++;
        if (p0 !== -1) begin failures++; $display("FAIL glitch_step: got %0d expected -1", p0); end
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        en      = 1'b0;
        inA     = '0;
        inB     = '0;
        clr_pos = '0;
        test_reset();
        test_latency();
`ifdef ENC_GLITCH_FILTER_EN
        test_glitch();
`else
        test_forward();
        test_reverse();
        test_errors();
        test_terminal();
        test_saturation();
        test_clear();
        test_enable();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
